// File: rtl/spi_master_periferico_multimodo_if.sv
// spi_master_periferico_multimodo_if: register bus between the front end and the SPI master.
interface spi_master_periferico_multimodo_if #(parameter int N = 4);
   logic          wr_i;
   logic          reg_sel_i;
   logic [N-1:0]  addr_i;
   logic [31:0]   entrada_i;
   logic [31:0]   salida_o;
   logic          busy_o;
   logic          done_o;
   modport master(output wr_i, reg_sel_i, addr_i, entrada_i, input salida_o, busy_o, done_o);
   modport slave(input wr_i, reg_sel_i, addr_i, entrada_i, output salida_o, busy_o, done_o);
endinterface

// File: rtl/spi_master_periferico_multimodo.sv
// spi_master_periferico_multimodo: register-driven multimode SPI master with RX write-back.
module spi_master_periferico_multimodo #(
   parameter int N       = 4,
   parameter int DATA_W  = 8,
   parameter int N_CS    = 2,
   parameter int CLK_DIV = 250
) (
   input  logic                  clk_fpga,
   input  logic                  rst,
   spi_master_periferico_multimodo_if.slave bus,
   output logic                  spi_sclk_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i,
   output logic [N_CS-1:0]       spi_cs_n_o
);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int HW = $clog2(2 * DATA_W);
   localparam logic [8:0] MAX_IDX = 9'((1 << N) - 1);
   typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, WORD_END, CS_HOLD, DONE} state_t;
   state_t            st;
   logic [18:0]       ctrl;
   logic [8:0]        n_rx;
   logic [DATA_W-1:0] mem [2**N];
   logic [N-1:0]      idx, end_q;
   logic              cpha_q;
   logic [3:0]        cs_q;
   logic [CW-1:0]     cnt;
   logic [HW-1:0]     h;
   logic [DATA_W-1:0] tx, rx, w_first, w_next;
   logic [N_CS-1:0]   cs_lo;
   logic [31:0]       e, salida;
   logic              busy, done, sclk, mosi, half_end;
   function automatic logic [N_CS-1:0] onehot(input logic [3:0] s);
      for (int i = 0; i < N_CS; i++) onehot[i] = (s == 4'(i));
   endfunction
   function automatic logic [DATA_W-1:0] src(input logic a1, input logic a0, input logic [DATA_W-1:0] w);
      return a1 ? '1 : a0 ? '0 : w;
   endfunction
   assign e          = bus.entrada_i;
   assign half_end   = cnt == CW'(CLK_DIV - 1);
   assign w_first    = src(e[2], e[3], mem[0]);
   assign w_next     = src(ctrl[2], ctrl[3], mem[N'(idx + N'(1))]);
   assign spi_sclk_o = sclk;
   assign spi_mosi_o = mosi;
   assign spi_cs_n_o = ~cs_lo;
   assign bus.salida_o = salida;
   assign bus.busy_o   = busy;
   assign bus.done_o   = done;
   // Buffer has no reset so stored words survive an aborted burst.
   always_ff @(posedge clk_fpga)
      if (!rst && st == IDLE && bus.wr_i && !bus.reg_sel_i) mem[bus.addr_i] <= e[DATA_W-1:0];
      else if (!rst && st == WORD_END) mem[idx] <= rx;
   always_ff @(posedge clk_fpga)
      salida <= rst ? '0 : bus.reg_sel_i ? {4'b0, n_rx, ctrl} : 32'(mem[bus.addr_i]);
   always_ff @(posedge clk_fpga) begin
      if (rst) begin
         st <= IDLE;
         ctrl <= '0;
         n_rx <= '0;
         idx <= '0;
         end_q <= '0;
         cpha_q <= 1'b0;
         cs_q <= '0;
         cnt <= '0;
         h <= '0;
         tx <= '0;
         rx <= '0;
         cs_lo <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         sclk <= 1'b0;
         mosi <= 1'b0;
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: if (bus.wr_i && bus.reg_sel_i) begin
               ctrl <= e[18:0];
               sclk <= e[5];
               cs_lo <= (e[1] | e[0]) ? onehot(e[9:6]) : '0;
               if (e[0]) begin
                  st <= CS_SETUP;
                  busy <= 1'b1;
                  n_rx <= '0;
                  idx <= '0;
                  cnt <= '0;
                  h <= '0;
                  cpha_q <= e[4];
                  cs_q <= e[9:6];
                  end_q <= (e[18:10] >= MAX_IDX) ? N'(MAX_IDX) : N'(e[18:10]);
                  if (!e[4]) begin
                     mosi <= w_first[DATA_W-1];
                     tx <= w_first << 1;
                  end else tx <= w_first;
               end
            end
            CS_SETUP: begin
               cnt <= half_end ? '0 : cnt + CW'(1);
               if (half_end) st <= XFER;
            end
            XFER: if (half_end) begin
               cnt <= '0;
               sclk <= ~sclk;
               if (h[0] == cpha_q) rx <= DATA_W'({rx, spi_miso_i});
               else begin
                  mosi <= tx[DATA_W-1];
                  tx <= tx << 1;
               end
               h <= (h == HW'(2 * DATA_W - 1)) ? '0 : h + HW'(1);
               if (h == HW'(2 * DATA_W - 1)) st <= WORD_END;
            end else cnt <= cnt + CW'(1);
            WORD_END: begin
               n_rx <= n_rx + 9'd1;
               if (idx == end_q) st <= CS_HOLD;
               else begin
                  st <= XFER;
                  idx <= idx + N'(1);
                  if (!cpha_q) begin
                     mosi <= w_next[DATA_W-1];
                     tx <= w_next << 1;
                  end else tx <= w_next;
               end
            end
            CS_HOLD: begin
               cnt <= half_end ? '0 : cnt + CW'(1);
               if (half_end) begin
                  st <= DONE;
                  cs_lo <= ctrl[1] ? onehot(cs_q) : '0;
               end
            end
            DONE: begin
               st <= IDLE;
               ctrl[0] <= 1'b0;
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_periferico_multimodo.sv
// tb_spi_master_periferico_multimodo: directed bench for the multimode SPI master.
module tb_spi_master_periferico_multimodo;
   localparam int N = 4, DW = 8, NCS = 2, CD = 2;
   logic clk = 1'b0, rst = 1'b1, loopb = 1'b1, miso_fix = 1'b0;
   logic sclk, mosi, miso;
   logic [NCS-1:0] cs_n;
   int checks = 0, errors = 0;
   spi_master_periferico_multimodo_if #(.N(N)) bus();
   assign miso = loopb ? mosi : miso_fix;
   spi_master_periferico_multimodo #(.N(N), .DATA_W(DW), .N_CS(NCS), .CLK_DIV(CD)) dut (
      .clk_fpga(clk), .rst(rst), .bus(bus),
      .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_n_o(cs_n)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic wr(input logic sel, input logic [N-1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.reg_sel_i = sel;
      bus.addr_i = a;
      bus.entrada_i = d;
      bus.wr_i = 1'b1;
      @(negedge clk);
      bus.wr_i = 1'b0;
   endtask
   task automatic rd(input logic sel, input logic [N-1:0] a, input string tag, input logic [31:0] exp);
      @(negedge clk);
      bus.reg_sel_i = sel;
      bus.addr_i = a;
      @(negedge clk);
      check(tag, bus.salida_o, exp);
   endtask
   // Call right after the send write: watches the burst cycle by cycle until done has passed.
   task automatic run(input string tag, input logic cp, input logic ph, input logic [1:0] ecs,
                      input int e_nb, input int e_ncs, input int e_nbits, input logic [31:0] e_bits);
      int nb = 0, nd = 0, ntog = 0, ncs = 0, nbits = 0, after = 0;
      logic [31:0] bits = '0;
      logic prev = sclk;
      for (int i = 0; i < 1000 && after < 3; i++) begin
         if (bus.busy_o) nb++;
         else if (nb > 0) after++;
         if (bus.done_o) nd++;
         if (bus.busy_o && cs_n == ecs) ncs++;
         if (sclk != prev) begin
            ntog++;
            if ((sclk != cp) ^ ph) begin
               bits = {bits[30:0], mosi};
               nbits++;
            end
         end
         prev = sclk;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, nb, e_nb);
      check({tag, "_done_pulses"}, nd, 1);
      check({tag, "_sclk_toggles"}, ntog, 2 * e_nbits);
      check({tag, "_cs_cycles"}, ncs, e_ncs);
      check({tag, "_mosi_bits"}, bits, e_bits);
   endtask
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 1000 && bus.busy_o; i++) @(negedge clk);
      check(tag, bus.busy_o, 1'b0);
   endtask
   initial begin
      bus.wr_i = 1'b0;
      bus.reg_sel_i = 1'b0;
      bus.addr_i = '0;
      bus.entrada_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_cs", cs_n, 2'b11);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_done", bus.done_o, 1'b0);
      rd(1'b1, 0, "rst_ctrl", 32'h0);
      wr(1'b0, 0, 32'hA5);
      wr(1'b0, 1, 32'h3C);
      wr(1'b1, 0, 32'h441);
      run("m0", 1'b0, 1'b0, 2'b01, 71, 70, 16, 32'hA53C);
      rd(1'b0, 0, "m0_buf0", 32'hA5);
      rd(1'b0, 1, "m0_buf1", 32'h3C);
      rd(1'b1, 0, "m0_ctrl", 32'h0010_0440);
      loopb = 1'b0;
      miso_fix = 1'b0;
      wr(1'b1, 0, 32'h30);
      check("m3_idle_sclk", sclk, 1'b1);
      wr(1'b1, 0, 32'h35);
      run("m3", 1'b1, 1'b1, 2'b10, 38, 37, 8, 32'hFF);
      check("m3_post_sclk", sclk, 1'b1);
      rd(1'b0, 0, "m3_buf0", 32'h0);
      rd(1'b1, 0, "m3_ctrl", 32'h0008_0034);
      loopb = 1'b1;
      wr(1'b1, 0, 32'h2);
      check("man_pre_cs", cs_n, 2'b10);
      wr(1'b0, 0, 32'h5A);
      wr(1'b1, 0, 32'h3);
      run("man", 1'b0, 1'b0, 2'b10, 38, 38, 8, 32'h5A);
      check("man_post_cs", cs_n, 2'b10);
      rd(1'b1, 0, "man_ctrl", 32'h0008_0002);
      wr(1'b1, 0, 32'h1);
      repeat (3) @(negedge clk);
      wr(1'b0, 0, 32'hFF);
      wr(1'b1, 0, 32'h3C0);
      wait_idle("bw_idle");
      rd(1'b0, 0, "bw_buf0", 32'h5A);
      rd(1'b1, 0, "bw_ctrl", 32'h0008_0000);
      wr(1'b1, 0, 32'h41);
      repeat (8) @(negedge clk);
      check("rm_cs_active", cs_n, 2'b01);
      rst = 1'b1;
      @(negedge clk);
      check("rm_cs", cs_n, 2'b11);
      check("rm_busy", bus.busy_o, 1'b0);
      check("rm_sclk", sclk, 1'b0);
      check("rm_mosi", mosi, 1'b0);
      check("rm_salida", bus.salida_o, 32'h0);
      rst = 1'b0;
      rd(1'b1, 0, "rm_ctrl", 32'h0);
      wr(1'b1, 0, 32'hC1);
      run("cs3", 1'b0, 1'b0, 2'b11, 38, 38, 8, 32'h5A);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_master_periferico_multimodo.md
# spi_master_periferico_multimodo

Parametrised SPI master peripheral: a 32-bit register interface (control register plus a 2^N-word data buffer) drives bursts of full-duplex SPI transfers on one of N_CS chip selects. It adds four SPI modes (CPOL/CPHA), configurable word width, MISO capture written back into the buffer, and manual or automatic chip-select control. It sits between the board-level switch/button front end and external SPI slaves, replacing the single-mode, transmit-only SPI interface.

## Interface
- N, 4: data-buffer address width; depth 2^N words, N ≤ 9.
- DATA_W, 8: SPI word width in bits, 1..32.
- N_CS, 2: number of chip-select lines, 1..16.
- CLK_DIV, 250: SCLK half-period in clk_fpga cycles, ≥ 1. At 100 MHz this gives 200 kHz.
- clk_fpga  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_i  in  1  write strobe, one write per high cycle.
- reg_sel_i  in  1  selects the target: 1 = control register, 0 = data buffer.
- addr_i  in  N  data-buffer word address; ignored when reg_sel_i = 1.
- entrada_i  in  32  write data.
- salida_o  out  32  registered read data.
- spi_sclk_o  out  1  SPI clock.
- spi_mosi_o  out  1  SPI data out, MSB first.
- spi_miso_i  in  1  SPI data in.
- spi_cs_n_o  out  N_CS  active-low chip selects.
- busy_o  out  1  high while a burst is in progress.
- done_o  out  1  one-cycle pulse at the end of a burst.

## Operation
- Control register bit layout:
  - [0] send: set by software, cleared by hardware at the end of the burst.
  - [1] cs_man; [2] all_1s; [3] all_0s; [4] cpha; [5] cpol.
  - [9:6] cs_sel; [18:10] n_tx_end (words − 1; low N bits used).
  - [27:19] n_rx (read-only); [31:28] always read 0.
- Writes:
  - reg_sel_i = 1: writes the control register; the n_rx field is not writable.
  - reg_sel_i = 0: writes entrada_i[DATA_W-1:0] to buffer[addr_i].
  - While busy_o = 1, all writes are ignored.
- Reads: salida_o is updated every cycle with the control register (reg_sel_i = 1) or the zero-extended buffer[addr_i] (reg_sel_i = 0).
- FSM states: IDLE → CS_SETUP → XFER → WORD_END → (XFER | CS_HOLD) → DONE → IDLE.
  - IDLE: a write with send = 1 clears n_rx and the word index, then goes to CS_SETUP.
  - CS_SETUP: lasts CLK_DIV cycles; SCLK held at cpol.
  - XFER: lasts 2·DATA_W half-periods.
  - WORD_END: lasts 1 cycle; stores the received word into buffer[idx], increments n_rx, then idx == n_tx_end → CS_HOLD, else idx+1 → XFER.
  - CS_HOLD: lasts CLK_DIV cycles.
  - DONE: lasts 1 cycle; clears send, pulses done_o.
- SPI modes:
  - SCLK idles at cpol.
  - cpha = 0: MOSI bit valid at CS_SETUP/word start; MISO sampled on the leading edge; MOSI shifts on the trailing edge.
  - cpha = 1: MOSI shifts on the leading edge; MISO sampled on the trailing edge.
- TX data source, in priority order: all_1s → all ones; else all_0s → all zeros; else buffer[idx]. RX data is stored in every case.
- Chip select:
  - Only line cs_sel can be driven low; all other lines stay high.
  - cs_sel ≥ N_CS → no line is asserted, but the transfer still runs.
  - cs_man = 1: line cs_sel is low whenever cs_man = 1, independent of the burst.
  - cs_man = 0: line cs_sel is low from CS_SETUP entry to CS_HOLD exit, held continuously across all words of the burst.
- cpol, cpha, cs_sel and n_tx_end are sampled when the burst starts and held until DONE.

## Timing
- Reset values:
  - spi_sclk_o 0, spi_mosi_o 0, spi_cs_n_o all ones.
  - busy_o 0, done_o 0, salida_o 0.
  - Control register 0 and FSM in IDLE; buffer contents are not reset.
- Send write accepted at cycle T:
  - busy_o and the auto CS assert at T+1.
  - busy_o stays high for CLK_DIV + W·(2·DATA_W·CLK_DIV + 1) + CLK_DIV + 1 cycles, where W = n_tx_end + 1.
  - done_o pulses on the first cycle busy_o is low.
- salida_o latency is 1 cycle. Buffer and n_rx updates are visible on the cycle after WORD_END.
- Simultaneous read and write to the same address in the same cycle: salida_o shows the old value.
- n_tx_end ≥ 2^N-1 is clamped to 2^N-1 (no index wrap).
- rst asserted mid-burst: on the next edge all outputs return to reset values and the burst is aborted; buffer words already stored are kept.

## Test plan
All scenarios use N = 4, DATA_W = 8, N_CS = 2, CLK_DIV = 2, with spi_miso_i looped to spi_mosi_o unless stated otherwise.
- Reset: hold rst for 3 cycles → sclk 0, mosi 0, cs_n 2'b11, busy 0, control register reads 0.
- Mode 0 burst:
  - Stimulus: buffer[0] = 0xA5, buffer[1] = 0x3C; control n_tx_end = 1, cs_sel = 1, send.
  - Response: MOSI sequence 10100101 00111100; cs_n = 2'b01 for the whole burst; busy_o high for 71 cycles; done_o pulses once.
  - After done: buffer reads back 0xA5, 0x3C; n_rx = 2.
- Mode 3 with all_1s, MISO tied 0 → SCLK idles at 1; MOSI constant 1; buffer[0] becomes 0x00.
- cs_man = 1, cs_sel = 0 → cs_n = 2'b10 before send, during the burst and after done.
- Write during busy:
  - Writes to buffer[0] and to the control register during the burst are ignored; read-back is unchanged.
  - rst asserted mid-burst → next cycle cs_n = 2'b11, busy 0, control register 0.
- cs_sel = 3 → cs_n stays 2'b11 while SCLK still toggles 16 times; done_o pulses.
